// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: bus layouts, access sizes and FSM states.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 155;
  localparam int MEM_WB_W  = 118;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } mem_state_e;

  // Incoming EXE->MEM bus, MSB first.
  typedef struct packed {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sext;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
  } exe_mem_t;

  // Outgoing MEM->WB bus, MSB first.
  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
  } mem_wb_t;

  // True when the instruction touches data memory.
  function automatic logic is_mem_op(input exe_mem_t b);
    return b.ld | b.st;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store enable/data replication and load
// lane extraction with sign or zero extension. Misaligned half/word
// accesses simply ignore the low address bits.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_sz,
  input  logic [1:0]  st_lane,
  input  logic [31:0] store_data,
  input  logic [1:0]  ld_sz,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sext,
  input  logic [31:0] rdata,
  output logic [3:0]  st_wen,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicate data across lanes and enable only the addressed lanes.
  always_comb begin
    st_wen   = 4'b1111;
    st_wdata = store_data;
    case (st_sz)
      SZ_B: begin
        st_wen   = 4'b0001 << st_lane;
        st_wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        st_wen   = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_wen   = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    byte_sel = rdata[7:0];
    case (ld_lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    case (ld_sz)
      SZ_B:    ld_value = {{24{ld_sext & byte_sel[7]}}, byte_sel};
      SZ_H:    ld_value = {{16{ld_sext & half_sel[15]}}, half_sel};
      default: ld_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads and stores against a req/ack data-memory port,
// passes non-memory ops straight through, and packs the MEM->WB bus.
//
// Data-memory handshake: dm_req and its fields (dm_wen, dm_addr, dm_wdata)
// are held stable from the first cycle of the request until the cycle in
// which dm_ack is high; the address phase transfers exactly in a cycle with
// dm_req & dm_ack, and the request is never withdrawn once raised (not even
// on cancel). Read data returns later as a single-cycle dm_rvalid strobe.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 MEM_adv,
  input  logic                 cancel,
  output logic                 dm_req,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic                 dm_ack,
  input  logic                 dm_rvalid,
  input  logic [31:0]          dm_rdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc,
  output mem_state_e           dbg_state
);

  exe_mem_t   in_bus;
  mem_wb_t    out_bus;

  mem_state_e state_q, state_d;
  logic       killed_q, killed_d;
  logic       dm_req_q, dm_req_d;
  logic [3:0] dm_wen_q, dm_wen_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  // Access attributes captured at issue so extraction does not depend on
  // the input bus still holding the same instruction.
  logic       is_ld_q, is_ld_d;
  logic [1:0] ld_sz_q, ld_sz_d;
  logic [1:0] ld_lane_q, ld_lane_d;
  logic       ld_sext_q, ld_sext_d;

  logic [3:0]  st_wen;
  logic [31:0] st_wdata;
  logic [31:0] ld_value;
  logic        start_access;

  assign in_bus = EXE_MEM_bus_r;

  mem_align u_align (
    .st_sz      (in_bus.sz),
    .st_lane    (in_bus.exe_result[1:0]),
    .store_data (in_bus.store_data),
    .ld_sz      (ld_sz_q),
    .ld_lane    (ld_lane_q),
    .ld_sext    (ld_sext_q),
    .rdata      (dm_rdata),
    .st_wen     (st_wen),
    .st_wdata   (st_wdata),
    .ld_value   (ld_value)
  );

  // A new access only starts from IDLE, never while a cancelled one drains.
  assign start_access = MEM_valid & is_mem_op(in_bus) & ~cancel & ~killed_q;

  // Next-state logic for the load/store FSM and its registered port fields.
  always_comb begin
    state_d    = state_q;
    killed_d   = killed_q;
    dm_req_d   = dm_req_q;
    dm_wen_d   = dm_wen_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    ld_data_d  = ld_data_q;
    is_ld_d    = is_ld_q;
    ld_sz_d    = ld_sz_q;
    ld_lane_d  = ld_lane_q;
    ld_sext_d  = ld_sext_q;

    case (state_q)
      S_IDLE: begin
        if (start_access) begin
          state_d    = S_REQ;
          dm_req_d   = 1'b1;
          dm_wen_d   = in_bus.ld ? 4'b0000 : st_wen;
          dm_addr_d  = {in_bus.exe_result[31:2], 2'b00};
          dm_wdata_d = st_wdata;
          is_ld_d    = in_bus.ld;
          ld_sz_d    = in_bus.sz;
          ld_lane_d  = in_bus.exe_result[1:0];
          ld_sext_d  = in_bus.sext;
        end
      end
      S_REQ: begin
        if (cancel) killed_d = 1'b1;
        if (dm_ack) begin
          dm_req_d = 1'b0;
          dm_wen_d = 4'b0000;
          if (is_ld_q)                state_d = S_WAIT_R;
          else if (killed_q | cancel) state_d = S_IDLE;
          else                        state_d = S_DONE;
        end
      end
      S_WAIT_R: begin
        if (cancel) killed_d = 1'b1;
        if (dm_rvalid) begin
          if (killed_q | cancel) begin
            state_d = S_IDLE;
          end else begin
            ld_data_d = ld_value;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (cancel | MEM_adv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The kill mark belongs to one access only.
    if (state_d == S_IDLE) killed_d = 1'b0;
  end

  // State and port registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      killed_q   <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_wen_q   <= 4'b0000;
      dm_addr_q  <= 32'd0;
      dm_wdata_q <= 32'd0;
      ld_data_q  <= 32'd0;
      is_ld_q    <= 1'b0;
      ld_sz_q    <= SZ_W;
      ld_lane_q  <= 2'd0;
      ld_sext_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      killed_q   <= killed_d;
      dm_req_q   <= dm_req_d;
      dm_wen_q   <= dm_wen_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      ld_data_q  <= ld_data_d;
      is_ld_q    <= is_ld_d;
      ld_sz_q    <= ld_sz_d;
      ld_lane_q  <= ld_lane_d;
      ld_sext_q  <= ld_sext_d;
    end
  end

  // Result packing; a killed instruction never writes the register file.
  always_comb begin
    out_bus.wen        = in_bus.wen & ~killed_q;
    out_bus.wdest      = in_bus.wdest;
    out_bus.mem_result = in_bus.ld ? ld_data_q : in_bus.exe_result;
    out_bus.lo_result  = in_bus.lo_result;
    out_bus.hi_write   = in_bus.hi_write;
    out_bus.lo_write   = in_bus.lo_write;
    out_bus.mfhi       = in_bus.mfhi;
    out_bus.mflo       = in_bus.mflo;
    out_bus.mtc0       = in_bus.mtc0;
    out_bus.mfc0       = in_bus.mfc0;
    out_bus.cp0r_addr  = in_bus.cp0r_addr;
    out_bus.syscall    = in_bus.syscall;
    out_bus.eret       = in_bus.eret;
    out_bus.pc         = in_bus.pc;
  end

  // Non-memory ops finish in the cycle they arrive; memory ops finish in DONE.
  assign MEM_over = ~cancel & ((state_q == S_DONE) |
                               ((state_q == S_IDLE) & MEM_valid & ~is_mem_op(in_bus)));

  assign dm_req     = dm_req_q;
  assign dm_wen     = dm_wen_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign MEM_WB_bus = out_bus;
  assign MEM_wdest  = in_bus.wdest & {5{MEM_valid}};
  assign MEM_pc     = in_bus.pc;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a single driver thread plays both the pipeline and
// the data memory, while a reference model (own memory image, arithmetic
// lane rules, expected-result queue) predicts every output each cycle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                 MEM_valid = 1'b0;
  logic                 MEM_adv = 1'b0;
  logic                 cancel = 1'b0;
  logic                 dm_ack = 1'b0;
  logic                 dm_rvalid = 1'b0;
  logic [31:0]          dm_rdata = 32'd0;
  exe_mem_t             bus_in = '0;
  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r;
  logic                 dm_req;
  logic [3:0]           dm_wen;
  logic [31:0]          dm_addr;
  logic [31:0]          dm_wdata;
  logic                 MEM_over;
  logic [MEM_WB_W-1:0]  MEM_WB_bus;
  logic [4:0]           MEM_wdest;
  logic [31:0]          MEM_pc;
  mem_state_e           dbg_state;
  mem_wb_t              wb_out;

  assign EXE_MEM_bus_r = bus_in;
  assign wb_out = MEM_WB_bus;

  mem_stage dut (
    .clk           (clk),
    .resetn        (resetn),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .MEM_adv       (MEM_adv),
    .cancel        (cancel),
    .dm_req        (dm_req),
    .dm_wen        (dm_wen),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rvalid     (dm_rvalid),
    .dm_rdata      (dm_rdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_pc        (MEM_pc),
    .dbg_state     (dbg_state)
  );

  // ---------------- model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit chk_state = 1'b0;
  bit exp_req = 1'b0;
  bit exp_over = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [3:0]  exp_wen = 4'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [MEM_WB_W-1:0] exp_q[$];
  logic [MEM_WB_W-1:0] exp_e;
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_addr = 32'd0;
  logic [3:0]  last_wen = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  mem_wb_t     last_wb = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] model_wen(input logic [1:0] sz, input logic [1:0] a);
    if (sz == SZ_B) return 4'd1 << a;
    if (sz == SZ_H) return (a >= 2'd2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == SZ_B) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == SZ_H) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input bit sext, input logic [1:0] a);
    logic [31:0] v;
    int bits;
    if (sz == SZ_B) begin
      bits = 8;
      v = (word >> (8 * a)) & 32'hFF;
    end else if (sz == SZ_H) begin
      bits = 16;
      v = (word >> ((a >= 2'd2) ? 16 : 0)) & 32'hFFFF;
    end else begin
      return word;
    end
    if (sext && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("dm_req", dm_req, exp_req);
      check("MEM_over", MEM_over, exp_over);
      check("MEM_wdest", MEM_wdest, MEM_valid ? bus_in.wdest : 5'd0);
      if (exp_req) begin
        check("dm_addr", dm_addr, exp_addr);
        check("dm_wen", dm_wen, exp_wen);
        if (exp_wen != 4'd0) check("dm_wdata", dm_wdata, exp_wdata);
        last_addr  = dm_addr;
        last_wen   = dm_wen;
        last_wdata = dm_wdata;
      end else begin
        check("dm_wen_idle", dm_wen, 4'd0);
      end
      if (chk_state) check("state_idle", dbg_state, S_IDLE);
      if (MEM_over && MEM_adv) begin
        if (exp_q.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL wb_bus: unexpected result %0h, none expected", MEM_WB_bus);
        end else begin
          exp_e = exp_q.pop_front();
          check("wb_bus", MEM_WB_bus, exp_e);
        end
        last_wb = wb_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 cancel in IDLE, 2 cancel in REQ, 3 cancel in WAIT_R,
  //       4 cancel in DONE, 5 reset in REQ followed by a stray rvalid.
  task automatic do_instr(input bit ld, input bit st, input logic [1:0] sz, input bit sext,
                          input logic [31:0] sd, input logic [31:0] ea, input int mode,
                          input int ack_dly, input int rv_dly);
    exe_mem_t b;
    mem_wb_t w;
    logic [159:0] r;
    logic [5:0] idx;
    logic [1:0] a;
    logic [31:0] rword;
    logic [3:0] mw;
    logic [31:0] md;
    bit k_f;
    int cat;
    int hold;

    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b = r[EXE_MEM_W-1:0];
    b.ld = ld;
    b.st = st;
    b.sz = sz;
    b.sext = sext;
    b.store_data = sd;
    b.exe_result = ea;
    if (ack_dly < 0) ack_dly = $urandom_range(0, 3);
    if (rv_dly < 1) rv_dly = $urandom_range(1, 3);
    idx = ea[7:2];
    a = ea[1:0];
    rword = 32'd0;
    k_f = 1'b0;

    w.wen = b.wen;
    w.wdest = b.wdest;
    w.mem_result = ld ? model_load(ref_mem[idx], sz, sext, a) : ea;
    w.lo_result = b.lo_result;
    w.hi_write = b.hi_write;
    w.lo_write = b.lo_write;
    w.mfhi = b.mfhi;
    w.mflo = b.mflo;
    w.mtc0 = b.mtc0;
    w.mfc0 = b.mfc0;
    w.cp0r_addr = b.cp0r_addr;
    w.syscall = b.syscall;
    w.eret = b.eret;
    w.pc = b.pc;

    mw = model_wen(sz, a);
    md = model_wdata(sz, sd);
    exp_addr = {ea[31:2], 2'b00};
    exp_wen = (st && !ld) ? mw : 4'd0;
    exp_wdata = md;
    if (st && !ld && mode != 1 && mode != 5)
      for (int k = 0; k < 4; k++)
        if (mw[k]) ref_mem[idx][8*k +: 8] = md[8*k +: 8];

    MEM_valid = 1'b1;
    bus_in = b;
    exp_req = 1'b0;

    if (!ld && !st) begin
      if (mode == 1) begin
        cancel = 1'b1;
        exp_over = 1'b0;
        step();
        cancel = 1'b0;
        MEM_valid = 1'b0;
        return;
      end
      exp_over = 1'b1;
      hold = $urandom_range(0, 1);
      repeat (hold) step();
      MEM_adv = 1'b1;
      exp_q.push_back(w);
      step();
      MEM_adv = 1'b0;
      MEM_valid = 1'b0;
      exp_over = 1'b0;
      return;
    end

    // cycle 0: FSM in IDLE sees the instruction
    exp_over = 1'b0;
    cancel = (mode == 1);
    step();
    if (mode == 1) begin
      cancel = 1'b0;
      MEM_valid = 1'b0;
      return;
    end

    // REQ phase
    exp_req = 1'b1;
    cat = (mode == 2) ? $urandom_range(0, ack_dly) : -1;
    for (int i = 0; i <= ack_dly; i++) begin
      if (mode == 5) begin
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        MEM_valid = 1'b0;
        exp_req = 1'b0;
        chk_state = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata = $urandom;
        step();
        dm_rvalid = 1'b0;
        step();
        chk_state = 1'b0;
        return;
      end
      if (i == cat) begin
        cancel = 1'b1;
        k_f = 1'b1;
      end
      dm_rdata = $urandom;
      if (i == ack_dly) begin
        dm_ack = 1'b1;
        if (st && !ld)
          for (int k = 0; k < 4; k++)
            if (dm_wen[k]) ram[dm_addr[7:2]][8*k +: 8] = dm_wdata[8*k +: 8];
        rword = ram[dm_addr[7:2]];
      end
      step();
      dm_ack = 1'b0;
      cancel = 1'b0;
      if (k_f) MEM_valid = 1'b0;
    end
    exp_req = 1'b0;

    // WAIT_R phase
    if (ld) begin
      cat = (mode == 3) ? $urandom_range(0, rv_dly - 1) : -1;
      for (int j = 0; j < rv_dly; j++) begin
        if (j == cat) begin
          cancel = 1'b1;
          k_f = 1'b1;
        end
        dm_rdata = $urandom;
        if (j == rv_dly - 1) begin
          dm_rvalid = 1'b1;
          dm_rdata = rword;
        end
        step();
        dm_rvalid = 1'b0;
        cancel = 1'b0;
        if (k_f) MEM_valid = 1'b0;
      end
    end
    if (k_f) return;

    // DONE phase
    exp_over = 1'b1;
    hold = $urandom_range(0, 2);
    repeat (hold) step();
    if (mode == 4) begin
      cancel = 1'b1;
      exp_over = 1'b0;
    end else begin
      MEM_adv = 1'b1;
      exp_q.push_back(w);
    end
    step();
    cancel = 1'b0;
    MEM_adv = 1'b0;
    MEM_valid = 1'b0;
    exp_over = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int rsel;
    int mode;
    bit ld;
    bit st;

    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end

    step();
    chk_en = 1'b1;
    step();
    check("reset_dm_req", dm_req, 1'b0);
    check("reset_dm_wen", dm_wen, 4'd0);
    check("reset_MEM_over", MEM_over, 1'b0);
    check("reset_state", dbg_state, S_IDLE);
    resetn = 1'b1;
    step();

    // addu passes straight through
    do_instr(1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'h0000_1234, 0, -1, 0);
    check("addu_result", last_wb.mem_result, 32'h0000_1234);

    // sb to byte 3 with a slow ack
    do_instr(1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_00AB, 32'h0000_0103, 0, 2, 0);
    check("sb_wen", last_wen, 4'b1000);
    check("sb_wdata", last_wdata, 32'hABAB_ABAB);
    check("sb_addr", last_addr, 32'h0000_0100);

    // lh from the upper half, signed then unsigned
    ram[0] = 32'h8001_7FFF;
    ref_mem[0] = 32'h8001_7FFF;
    do_instr(1'b1, 1'b0, SZ_H, 1'b1, 32'd0, 32'h0000_0202, 0, 1, 3);
    check("lh_sext", last_wb.mem_result, 32'hFFFF_8001);
    do_instr(1'b1, 1'b0, SZ_H, 1'b0, 32'd0, 32'h0000_0202, 0, 0, 1);
    check("lh_zext", last_wb.mem_result, 32'h0000_8001);

    // lw cancelled while waiting for data, then a fresh lw
    do_instr(1'b1, 1'b0, SZ_W, 1'b0, 32'd0, 32'h0000_0044, 3, 1, 3);
    do_instr(1'b1, 1'b0, SZ_W, 1'b0, 32'd0, 32'h0000_0048, 0, 0, 1);
    check("lw_after_cancel", last_wb.mem_result, ref_mem[6'h12]);

    // ack held off for 10 cycles
    do_instr(1'b0, 1'b1, SZ_W, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 0, 10, 0);
    check("sw_long_wdata", last_wdata, 32'hDEAD_BEEF);

    // reset in the middle of a request
    do_instr(1'b1, 1'b0, SZ_W, 1'b0, 32'd0, 32'h0000_0030, 5, 3, 0);
    check("post_reset_req", dm_req, 1'b0);
    check("post_reset_over", MEM_over, 1'b0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      ld = (kind >= 3 && kind <= 5);
      st = (kind >= 6);
      rsel = $urandom_range(0, 19);
      if (rsel <= 13) mode = 0;
      else if (rsel == 14) mode = 1;
      else if (rsel <= 16) mode = 2;
      else if (rsel == 17) mode = ld ? 3 : 0;
      else if (rsel == 18) mode = 4;
      else mode = (n % 4 == 0) ? 5 : 0;
      do_instr(ld, st, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               mode, -1, 0);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
